xbar_rsp_buffer: RTL and testbench
==================================

XBAR_RSP_BUFFER -- requirements
Module: xbar_rsp_buffer

Interface
REQ-001 SHALL have parameter Cfg, default '0: mpc_cfg_t configuration passed through from the xbar top.
REQ-002 SHALL have parameter DEPTH, default 4: entries per bank response FIFO; power of two, minimum 2.
REQ-003 SHALL use one clock and a synchronous, active-low reset, with ports clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 d_bank_N_rsp_valid  input  1  bank N (N=0..3) offers a response.
REQ-007 d_bank_N_rsp_ready  output  1  bank N response accepted this cycle when valid.
REQ-008 d_bank_N_rsp  input  channel_rsp_t  response payload from bank N.
REQ-009 d_bank_N_rsp_ch_1hot_id  input  3  destination channel, one-hot.
REQ-010 u_channel_M_rsp_valid  output  1  channel M (M=0..2) response available.
REQ-011 u_channel_M_rsp_ready  input  1  channel M accepts the response.
REQ-012 u_channel_M_rsp  output  channel_rsp_t  response to channel M.

Function
REQ-013 SHALL keep one DEPTH-entry FIFO per bank; each entry stores the payload and a 3-bit destination.
REQ-014 Push on bank N SHALL occur when d_bank_N_rsp_valid & d_bank_N_rsp_ready.
REQ-015 d_bank_N_rsp_ready SHALL equal !full of FIFO N, with no same-cycle pop bypass; a full FIFO with a pop that cycle still reports ready=0.
REQ-016 A push with ch_1hot_id == 3'b000 SHALL be handshaked and discarded without being stored.
REQ-017 A push with a multi-hot ch_1hot_id SHALL store only the lowest set bit.
REQ-018 FIFO N SHALL request channel M when FIFO N is non-empty and its head destination bit M is set.
REQ-019 Each channel SHALL arbitrate among its requesting banks with an independent round-robin pointer.
REQ-020 The round-robin pointer SHALL reset to bank 0 and, after a handshake granted to bank b, SHALL give highest priority to bank (b+1) mod 4.
REQ-021 The round-robin pointer SHALL NOT advance while channel M is valid and not ready; grant and payload stay stable until the handshake.
REQ-022 u_channel_M_rsp_valid SHALL be high when any bank requests channel M.
REQ-023 u_channel_M_rsp SHALL carry the granted head payload when valid and SHALL be '0 otherwise.
REQ-024 Pop of FIFO N SHALL occur on u_channel_M_rsp_valid & u_channel_M_rsp_ready when bank N is granted to channel M.
REQ-025 One-hot heads cannot target two channels, so there SHALL be at most one pop per FIFO per cycle.
REQ-026 Latency SHALL be 1 cycle minimum: an entry pushed in cycle T is presented at the earliest in cycle T+1; there is no combinational bank-to-channel path.
REQ-027 Order SHALL be preserved per bank; no ordering across banks.
REQ-028 Read and write pointers SHALL be log2(DEPTH)+1 bits, wrap modulo 2*DEPTH, with full/empty decoded from the MSB.
REQ-029 Simultaneous push and pop on a non-full, non-empty FIFO SHALL keep the count unchanged.

Reset
REQ-030 While rst_n=0 at a clock edge, all FIFOs SHALL become empty, all pointers 0, and all round-robin pointers bank 0.
REQ-031 While rst_n=0, all d_bank_N_rsp_ready and u_channel_M_rsp_valid SHALL be 0 and all u_channel_M_rsp SHALL be '0.
REQ-032 Reset mid-transfer SHALL drop all stored entries; no entry reappears after reset.

Structure
REQ-033 channel_rsp_t SHALL be defined in mpc_types alongside channel_req_t; there are no local typedefs.
REQ-034 Bank and channel counts (4, 3) SHALL be constants in mpc_types.
REQ-035 A sub-module xbar_rsp_fifo (one bank FIFO: push, pop, head, full, empty) SHALL be instantiated 4 times via generate; round-robin arbitration stays in the top module.

Verification
REQ-036 Single transfer: bank 2 pushes payload 0xA5 with dest 3'b010 at cycle 0 -> channel 1 valid with 0xA5 at cycle 1, pops, and FIFO 2 is empty at cycle 2.
REQ-037 Contention: banks 0–3 all push dest 3'b001 in the same cycle, channel 0 ready held high -> channel 0 receives bank order 0,1,2,3 on cycles 1–4; a second identical round starts at bank 0 (pointer wrapped).
REQ-038 Full/backpressure: channel 2 ready=0, bank 1 pushes 5 entries dest 3'b100 -> ready drops after 4 accepted; raise ready -> 4 entries are drained in push order, then ready=1 again.
REQ-039 Stall stability: channel 0 valid, ready=0 for 3 cycles while bank 3 also requests -> payload and grant remain unchanged until the handshake.
REQ-040 Illegal destination: a push with dest 3'b000 is accepted with no channel valid; dest 3'b110 is delivered to channel 1 only.
REQ-041 Reset mid-operation: FIFOs hold 2 entries and rst_n=0 for 1 cycle -> all valid=0 and ready=0 during reset, FIFOs empty after reset, and no stale response appears.

Source files
------------

// File: rtl/mpc_types.sv
// Shared types and constants for the memory-port crossbar.
// Bank/channel counts and the request/response payload formats live here.
package mpc_types;

    localparam int unsigned NUM_BANKS    = 4;
    localparam int unsigned NUM_CHANNELS = 3;
    localparam int unsigned BANK_W       = $clog2(NUM_BANKS);

    typedef struct packed {
        logic [7:0] id;
        logic       en;
    } mpc_cfg_t;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
    } channel_req_t;

    typedef struct packed {
        logic [3:0]  src;
        logic [31:0] data;
    } channel_rsp_t;

    // Keeps only the lowest set bit, so a multi-hot destination becomes one-hot.
    function automatic logic [NUM_CHANNELS-1:0] lowest_set(input logic [NUM_CHANNELS-1:0] v);
        return v & (~v + NUM_CHANNELS'(1));
    endfunction

endpackage

// File: rtl/xbar_rsp_fifo.sv
// One bank response FIFO: payload plus one-hot destination per entry.
// Pointers carry an extra wrap bit so full and empty are told apart by the MSB.
module xbar_rsp_fifo
    import mpc_types::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_i,
    input  channel_rsp_t            push_data_i,
    input  logic [NUM_CHANNELS-1:0] push_dest_i,
    input  logic                    pop_i,
    output channel_rsp_t            head_data_o,
    output logic [NUM_CHANNELS-1:0] head_dest_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    channel_rsp_t            mem_data_q [DEPTH];
    logic [NUM_CHANNELS-1:0] mem_dest_q [DEPTH];
    logic [AW:0]             wr_ptr_q, wr_ptr_d;
    logic [AW:0]             rd_ptr_q, rd_ptr_d;
    logic                    do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    assign head_data_o = mem_data_q[rd_ptr_q[AW-1:0]];
    assign head_dest_o = mem_dest_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; resetting the pointers is enough to drop every entry.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_data_q[wr_ptr_q[AW-1:0]] <= push_data_i;
            mem_dest_q[wr_ptr_q[AW-1:0]] <= push_dest_i;
        end
    end

endmodule

// File: rtl/xbar_rsp_buffer.sv
// Buffers bank responses per bank and routes FIFO heads to channels
// through per-channel round-robin arbiters with stall-stable grants.
module xbar_rsp_buffer
    import mpc_types::*;
#(
    parameter mpc_cfg_t    Cfg   = '0,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         d_bank_0_rsp_valid,
    output logic         d_bank_0_rsp_ready,
    input  channel_rsp_t d_bank_0_rsp,
    input  logic [2:0]   d_bank_0_rsp_ch_1hot_id,
    input  logic         d_bank_1_rsp_valid,
    output logic         d_bank_1_rsp_ready,
    input  channel_rsp_t d_bank_1_rsp,
    input  logic [2:0]   d_bank_1_rsp_ch_1hot_id,
    input  logic         d_bank_2_rsp_valid,
    output logic         d_bank_2_rsp_ready,
    input  channel_rsp_t d_bank_2_rsp,
    input  logic [2:0]   d_bank_2_rsp_ch_1hot_id,
    input  logic         d_bank_3_rsp_valid,
    output logic         d_bank_3_rsp_ready,
    input  channel_rsp_t d_bank_3_rsp,
    input  logic [2:0]   d_bank_3_rsp_ch_1hot_id,
    output logic         u_channel_0_rsp_valid,
    input  logic         u_channel_0_rsp_ready,
    output channel_rsp_t u_channel_0_rsp,
    output logic         u_channel_1_rsp_valid,
    input  logic         u_channel_1_rsp_ready,
    output channel_rsp_t u_channel_1_rsp,
    output logic         u_channel_2_rsp_valid,
    input  logic         u_channel_2_rsp_ready,
    output channel_rsp_t u_channel_2_rsp
);

    logic cfg_unused;
    assign cfg_unused = ^Cfg;

    logic [NUM_BANKS-1:0]    bank_valid, bank_ready, fifo_push, fifo_pop, fifo_full, fifo_empty;
    channel_rsp_t            bank_data [NUM_BANKS];
    channel_rsp_t            head_data [NUM_BANKS];
    logic [NUM_CHANNELS-1:0] bank_dest [NUM_BANKS];
    logic [NUM_CHANNELS-1:0] head_dest [NUM_BANKS];

    logic [NUM_CHANNELS-1:0] ch_ready, ch_valid, ch_hs;
    channel_rsp_t            ch_data  [NUM_CHANNELS];
    logic [BANK_W-1:0]       ch_grant [NUM_CHANNELS];

    assign bank_valid = {d_bank_3_rsp_valid, d_bank_2_rsp_valid, d_bank_1_rsp_valid, d_bank_0_rsp_valid};
    assign bank_data[0] = d_bank_0_rsp;
    assign bank_data[1] = d_bank_1_rsp;
    assign bank_data[2] = d_bank_2_rsp;
    assign bank_data[3] = d_bank_3_rsp;
    assign bank_dest[0] = d_bank_0_rsp_ch_1hot_id;
    assign bank_dest[1] = d_bank_1_rsp_ch_1hot_id;
    assign bank_dest[2] = d_bank_2_rsp_ch_1hot_id;
    assign bank_dest[3] = d_bank_3_rsp_ch_1hot_id;
    assign {d_bank_3_rsp_ready, d_bank_2_rsp_ready, d_bank_1_rsp_ready, d_bank_0_rsp_ready} = bank_ready;

    assign ch_ready = {u_channel_2_rsp_ready, u_channel_1_rsp_ready, u_channel_0_rsp_ready};
    assign {u_channel_2_rsp_valid, u_channel_1_rsp_valid, u_channel_0_rsp_valid} = ch_valid;
    assign u_channel_0_rsp = ch_data[0];
    assign u_channel_1_rsp = ch_data[1];
    assign u_channel_2_rsp = ch_data[2];

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        // Destination 000 is handshaked but never written.
        assign bank_ready[gi] = rst_n & ~fifo_full[gi];
        assign fifo_push[gi]  = bank_valid[gi] & bank_ready[gi] & (|bank_dest[gi]);

        xbar_rsp_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk         (clk),
            .rst_n       (rst_n),
            .push_i      (fifo_push[gi]),
            .push_data_i (bank_data[gi]),
            .push_dest_i (lowest_set(bank_dest[gi])),
            .pop_i       (fifo_pop[gi]),
            .head_data_o (head_data[gi]),
            .head_dest_o (head_dest[gi]),
            .full_o      (fifo_full[gi]),
            .empty_o     (fifo_empty[gi])
        );
    end

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
        logic [NUM_BANKS-1:0] req;
        logic [BANK_W-1:0]    rr_q, rr_d, lock_idx_q, grant, idx;
        logic                 lock_q, lock_d, found, valid, hs;

        always_comb begin
            req = '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                req[b] = ~fifo_empty[b] & head_dest[b][gi];
            end
        end

        // A stalled grant is locked so a newly arriving higher-priority bank cannot steal it.
        always_comb begin
            grant = rr_q;
            idx   = '0;
            found = 1'b0;
            for (int k = 0; k < NUM_BANKS; k++) begin
                idx = rr_q + BANK_W'(k);
                if (!found && req[idx]) begin
                    grant = idx;
                    found = 1'b1;
                end
            end
            if (lock_q) grant = lock_idx_q;
        end

        assign valid  = rst_n & (|req);
        assign hs     = valid & ch_ready[gi];
        assign rr_d   = hs ? grant + BANK_W'(1) : rr_q;
        assign lock_d = valid & ~ch_ready[gi];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rr_q       <= '0;
                lock_q     <= 1'b0;
                lock_idx_q <= '0;
            end else begin
                rr_q       <= rr_d;
                lock_q     <= lock_d;
                lock_idx_q <= grant;
            end
        end

        assign ch_valid[gi] = valid;
        assign ch_hs[gi]    = hs;
        assign ch_grant[gi] = grant;
        assign ch_data[gi]  = valid ? head_data[grant] : '0;
    end

    // A one-hot head requests a single channel, so each FIFO sees at most one pop.
    always_comb begin
        fifo_pop = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int m = 0; m < NUM_CHANNELS; m++) begin
                if (ch_hs[m] && ch_grant[m] == BANK_W'(b)) fifo_pop[b] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xbar_rsp_buffer.sv
// Scoreboard bench for xbar_rsp_buffer: expected responses are queued per
// channel as pushes are accepted and checked by a monitor on each handshake.
module tb_xbar_rsp_buffer;
    import mpc_types::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         bv   [NUM_BANKS];
    logic         br   [NUM_BANKS];
    channel_rsp_t bd   [NUM_BANKS];
    logic [2:0]   bdst [NUM_BANKS];
    logic         cv   [NUM_CHANNELS];
    logic         cr   [NUM_CHANNELS];
    channel_rsp_t cd   [NUM_CHANNELS];

    int           total = 0;
    int           bad = 0;
    int           hs_cnt [NUM_CHANNELS];
    channel_rsp_t expq [NUM_CHANNELS][$];
    channel_rsp_t mon_exp;

    always #5 clk = ~clk;

    xbar_rsp_buffer #(.Cfg('0), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_bank_0_rsp_valid(bv[0]), .d_bank_0_rsp_ready(br[0]), .d_bank_0_rsp(bd[0]), .d_bank_0_rsp_ch_1hot_id(bdst[0]),
        .d_bank_1_rsp_valid(bv[1]), .d_bank_1_rsp_ready(br[1]), .d_bank_1_rsp(bd[1]), .d_bank_1_rsp_ch_1hot_id(bdst[1]),
        .d_bank_2_rsp_valid(bv[2]), .d_bank_2_rsp_ready(br[2]), .d_bank_2_rsp(bd[2]), .d_bank_2_rsp_ch_1hot_id(bdst[2]),
        .d_bank_3_rsp_valid(bv[3]), .d_bank_3_rsp_ready(br[3]), .d_bank_3_rsp(bd[3]), .d_bank_3_rsp_ch_1hot_id(bdst[3]),
        .u_channel_0_rsp_valid(cv[0]), .u_channel_0_rsp_ready(cr[0]), .u_channel_0_rsp(cd[0]),
        .u_channel_1_rsp_valid(cv[1]), .u_channel_1_rsp_ready(cr[1]), .u_channel_1_rsp(cd[1]),
        .u_channel_2_rsp_valid(cv[2]), .u_channel_2_rsp_ready(cr[2]), .u_channel_2_rsp(cd[2])
    );

    function automatic channel_rsp_t mk(input int src, input int data);
        channel_rsp_t r;
        r.src  = 4'(src);
        r.data = 32'(data);
        return r;
    endfunction

    // Channel a destination resolves to (lowest set bit), -1 when discarded.
    function automatic int dest_ch(input logic [2:0] d);
        for (int i = 0; i < 3; i++) if (d[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        for (int m = 0; m < NUM_CHANNELS; m++) begin
            if (cv[m] === 1'b1 && cr[m] === 1'b1) begin
                hs_cnt[m]++;
                total++;
                if (expq[m].size() == 0) begin
                    bad++;
                    $display("FAIL mon_unexpected_ch%0d: got %h required no response", m, cd[m]);
                end else begin
                    mon_exp = expq[m].pop_front();
                    if (cd[m] !== mon_exp) begin
                        bad++;
                        $display("FAIL mon_payload_ch%0d: got %h required %h", m, cd[m], mon_exp);
                    end
                    $display("ch%0d rsp src=%0d data=%h", m, cd[m].src, cd[m].data);
                end
            end else if (cv[m] !== 1'b1) begin
                total++;
                if (cd[m] !== '0) begin
                    bad++;
                    $display("FAIL mon_idle_payload_ch%0d: got %h required 0", m, cd[m]);
                end
            end
        end
    end

    task automatic idle_inputs();
        for (int b = 0; b < NUM_BANKS; b++) begin
            bv[b] = 1'b0; bd[b] = '0; bdst[b] = 3'b000;
        end
    endtask

    task automatic clear_sb();
        for (int m = 0; m < NUM_CHANNELS; m++) begin
            expq[m].delete();
            hs_cnt[m] = 0;
        end
    endtask

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_sb();
    endtask

    task automatic push_one(input int b, input logic [2:0] dest, input int data, output bit acc);
        bv[b] = 1'b1; bdst[b] = dest; bd[b] = mk(b, data);
        @(negedge clk);
        acc = br[b];
        if (acc && dest_ch(dest) >= 0) expq[dest_ch(dest)].push_back(mk(b, data));
        @(posedge clk); #1;
        bv[b] = 1'b0;
    endtask

    task automatic wait_empty(input int m);
        for (int i = 0; i < 60 && expq[m].size() != 0; i++) @(negedge clk);
        total++;
        if (expq[m].size() != 0) begin
            bad++;
            $display("FAIL drain_timeout_ch%0d: got %0d left required 0", m, expq[m].size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        for (int m = 0; m < NUM_CHANNELS; m++) cr[m] = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int b = 0; b < NUM_BANKS; b++) begin
            total++;
            if (br[b] !== 1'b0) begin bad++; $display("FAIL reset_ready_b%0d: got %b required 0", b, br[b]); end
        end
        for (int m = 0; m < NUM_CHANNELS; m++) begin
            total++;
            if (cv[m] !== 1'b0) begin bad++; $display("FAIL reset_valid_ch%0d: got %b required 0", m, cv[m]); end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_sb();
        @(negedge clk);
        for (int b = 0; b < NUM_BANKS; b++) begin
            total++;
            if (br[b] !== 1'b1) begin bad++; $display("FAIL post_reset_ready_b%0d: got %b required 1", b, br[b]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        bit acc;
        do_reset();
        cr[1] = 1'b1;
        bv[2] = 1'b1; bdst[2] = 3'b010; bd[2] = mk(2, 'hA5);
        @(negedge clk);
        total++;
        if (cv[1] !== 1'b0) begin bad++; $display("FAIL single_no_comb_path: got valid=%b required 0", cv[1]); end
        acc = br[2];
        total++;
        if (acc !== 1'b1) begin bad++; $display("FAIL single_push_ready: got %b required 1", acc); end
        if (acc) expq[1].push_back(mk(2, 'hA5));
        @(posedge clk); #1;
        bv[2] = 1'b0;
        @(negedge clk);
        total++;
        if (cv[1] !== 1'b1 || cd[1].data !== 32'hA5) begin
            bad++; $display("FAIL single_cycle1: got valid=%b data=%h required valid=1 data=a5", cv[1], cd[1].data);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (cv[1] !== 1'b0 || br[2] !== 1'b1) begin
            bad++; $display("FAIL single_cycle2_empty: got valid=%b ready=%b required valid=0 ready=1", cv[1], br[2]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        do_reset();
        cr[0] = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bv[b] = 1'b1; bdst[b] = 3'b001; bd[b] = mk(b, r * 16 + b);
            end
            @(negedge clk);
            for (int b = 0; b < NUM_BANKS; b++) if (br[b]) expq[0].push_back(mk(b, r * 16 + b));
            @(posedge clk); #1;
            idle_inputs();
            for (int i = 0; i < NUM_BANKS; i++) begin
                @(negedge clk);
                total++;
                if (cv[0] !== 1'b1 || cd[0].src !== 4'(i)) begin
                    bad++; $display("FAIL contention_r%0d_slot%0d: got valid=%b src=%0d required valid=1 src=%0d", r, i, cv[0], cd[0].src, i);
                end
                @(posedge clk); #1;
            end
        end
        wait_empty(0);
    endtask

    task automatic test_backpressure();
        do_reset();
        cr[2] = 1'b0;
        bv[1] = 1'b1; bdst[1] = 3'b100;
        for (int i = 0; i < 5; i++) begin
            bd[1] = mk(1, 'h100 + i);
            @(negedge clk);
            total++;
            if (br[1] !== (i < 4)) begin bad++; $display("FAIL bp_ready_push%0d: got %b required %b", i, br[1], (i < 4)); end
            if (br[1]) expq[2].push_back(mk(1, 'h100 + i));
            @(posedge clk); #1;
        end
        bv[1] = 1'b0;
        cr[2] = 1'b1;
        @(negedge clk);
        total++;
        if (br[1] !== 1'b0) begin bad++; $display("FAIL bp_no_bypass: got ready=%b required 0", br[1]); end
        @(posedge clk); #1;
        wait_empty(2);
        @(negedge clk);
        total++;
        if (br[1] !== 1'b1 || hs_cnt[2] !== 4) begin
            bad++; $display("FAIL bp_drained: got ready=%b count=%0d required ready=1 count=4", br[1], hs_cnt[2]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        bit acc;
        do_reset();
        cr[0] = 1'b0;
        push_one(3, 3'b001, 'h33, acc);
        push_one(0, 3'b001, 'h44, acc);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (cv[0] !== 1'b1 || cd[0] !== mk(3, 'h33)) begin
                bad++; $display("FAIL stall_hold_%0d: got valid=%b rsp=%h required valid=1 rsp=%h", i, cv[0], cd[0], mk(3, 'h33));
            end
            @(posedge clk); #1;
        end
        cr[0] = 1'b1;
        wait_empty(0);
    endtask

    task automatic test_illegal();
        bit acc;
        do_reset();
        for (int m = 0; m < NUM_CHANNELS; m++) cr[m] = 1'b1;
        push_one(0, 3'b000, 'h77, acc);
        total++;
        if (acc !== 1'b1) begin bad++; $display("FAIL illegal_accept: got %b required 1", acc); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int m = 0; m < NUM_CHANNELS; m++) begin
                total++;
                if (cv[m] !== 1'b0) begin bad++; $display("FAIL illegal_discard_ch%0d: got valid=%b required 0", m, cv[m]); end
            end
            @(posedge clk); #1;
        end
        push_one(1, 3'b110, 'h66, acc);
        wait_empty(1);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (hs_cnt[1] !== 1 || hs_cnt[2] !== 0) begin
            bad++; $display("FAIL multihot_route: got ch1=%0d ch2=%0d required ch1=1 ch2=0", hs_cnt[1], hs_cnt[2]);
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        do_reset();
        for (int m = 0; m < NUM_CHANNELS; m++) cr[m] = 1'b0;
        push_one(0, 3'b001, 'h11, acc);
        push_one(0, 3'b001, 'h12, acc);
        @(negedge clk);
        total++;
        if (cv[0] !== 1'b1) begin bad++; $display("FAIL rmid_loaded: got valid=%b required 1", cv[0]); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        for (int b = 0; b < NUM_BANKS; b++) begin
            total++;
            if (br[b] !== 1'b0) begin bad++; $display("FAIL rmid_ready_b%0d: got %b required 0", b, br[b]); end
        end
        for (int m = 0; m < NUM_CHANNELS; m++) begin
            total++;
            if (cv[m] !== 1'b0) begin bad++; $display("FAIL rmid_valid_ch%0d: got %b required 0", m, cv[m]); end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_sb();
        for (int m = 0; m < NUM_CHANNELS; m++) cr[m] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (cv[0] !== 1'b0 || br[0] !== 1'b1) begin
                bad++; $display("FAIL rmid_flushed_%0d: got valid=%b ready=%b required valid=0 ready=1", i, cv[0], br[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        idle_inputs();
        for (int m = 0; m < NUM_CHANNELS; m++) begin
            cr[m] = 1'b0;
            hs_cnt[m] = 0;
        end
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_stall();
        test_illegal();
        test_reset_mid();
        for (int m = 0; m < NUM_CHANNELS; m++) begin
            total++;
            if (expq[m].size() != 0) begin
                bad++; $display("FAIL final_queue_ch%0d: got %0d left required 0", m, expq[m].size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
